// File: rtl/hc_sb_pkg.sv
// hc_sb_pkg: shared types and defaults for the second-generation hazard controller.
//   fwd_sel_t     - E-stage operand mux select (no bypass / from M / from W)
//   NREG_DEF      - default architectural register count (x0 hardwired zero)
//   LONG_MAX_DEF  - default limit on outstanding long-latency (MDU) ops
package hc_sb_pkg;

  localparam int NREG_DEF     = 32;
  localparam int LONG_MAX_DEF = 4;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_M    = 2'd1,
    FWD_W    = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/hc_scoreboard.sv
// hc_scoreboard: pending-register tracker for long-latency ops that retire
// outside the normal pipeline.
//   clk, reset        - clock, synchronous active-high reset
//   issue, issue_rd   - a long op leaves E and will write issue_rd later
//   done, done_rd     - the long unit writes done_rd this cycle
//   pending[NREG]     - one bit per register with a result still in flight
//   full              - outstanding count has reached LONG_MAX
//   err               - sticky: a completion arrived that was never issued
module hc_scoreboard
  import hc_sb_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int LONG_MAX = LONG_MAX_DEF,
  parameter int REG_W    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             done,
  input  logic [REG_W-1:0] done_rd,
  output logic [NREG-1:0]  pending,
  output logic             full,
  output logic             err
);

  localparam int CNT_W = $clog2(LONG_MAX + 1);

  logic [CNT_W-1:0] count;
  logic             done_ok;

  // A completion is only honoured if something is outstanding and its
  // register is actually marked; anything else is flagged, never applied.
  assign done_ok = done && (count != '0) && pending[done_rd];
  assign full    = (count == CNT_W'(LONG_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      // Clear before set so a coincident issue to the same register keeps it marked.
      if (done_ok)
        pending[done_rd] <= 1'b0;
      if (issue && (issue_rd != '0))
        pending[issue_rd] <= 1'b1;

      if (issue && !done_ok && !full)
        count <= count + 1'b1;
      else if (!issue && done_ok)
        count <= count - 1'b1;

      if (done && !done_ok)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/hc_sb.sv
// hc_sb: hazard controller for the F/D/E/M/W core.
//   Inputs : pipeline-stage register ids and write/load/long flags, je (taken
//            jump in E), busy_M (LSU hold), long_done/long_rd (MDU retire).
//   Outputs: stall_*/flush_* for each pipeline register, fwd_a_E/fwd_b_E
//            operand selects, sb_pending, long_full, sb_err.
// Control priority: busy_M > je > D-stage hazard. Forwarding is independent
// of the stall logic and always reflects the current M/W contents.
module hc_sb
  import hc_sb_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int LONG_MAX = LONG_MAX_DEF,
  parameter int REG_W    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             je,
  input  logic             busy_M,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [REG_W-1:0] rd_D,
  input  logic             long_D,
  input  logic [REG_W-1:0] rs1_E,
  input  logic [REG_W-1:0] rs2_E,
  input  logic [REG_W-1:0] rd_E,
  input  logic             we_E,
  input  logic             load_E,
  input  logic             long_E,
  input  logic [REG_W-1:0] rd_M,
  input  logic             we_M,
  input  logic [REG_W-1:0] rd_W,
  input  logic             we_W,
  input  logic             long_done,
  input  logic [REG_W-1:0] long_rd,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             stall_E,
  output logic             flush_E,
  output logic             stall_M,
  output logic             flush_M,
  output logic             stall_W,
  output logic             flush_W,
  output fwd_sel_t         fwd_a_E,
  output fwd_sel_t         fwd_b_E,
  output logic [NREG-1:0]  sb_pending,
  output logic             long_full,
  output logic             sb_err
);

  logic issue;
  logic load_use;
  logic sb_raw;
  logic sb_waw;
  logic hazard_D;

  // A long op only counts as issued once it actually leaves E.
  assign issue = long_E && we_E && (rd_E != '0) && !busy_M;

  hc_scoreboard #(
    .NREG     (NREG),
    .LONG_MAX (LONG_MAX),
    .REG_W    (REG_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_rd (rd_E),
    .done     (long_done),
    .done_rd  (long_rd),
    .pending  (sb_pending),
    .full     (long_full),
    .err      (sb_err)
  );

  function automatic fwd_sel_t fwd_pick(
    input logic [REG_W-1:0] rs,
    input logic             m_we,
    input logic [REG_W-1:0] m_rd,
    input logic             w_we,
    input logic [REG_W-1:0] w_rd
  );
    if (m_we && (m_rd == rs) && (m_rd != '0))
      return FWD_M;
    else if (w_we && (w_rd == rs) && (w_rd != '0))
      return FWD_W;
    else
      return FWD_NONE;
  endfunction

  assign fwd_a_E = fwd_pick(rs1_E, we_M, rd_M, we_W, rd_W);
  assign fwd_b_E = fwd_pick(rs2_E, we_M, rd_M, we_W, rd_W);

  // No bypass exists for long_done: a reader of the retiring register sees
  // its pending bit for one more cycle and stalls until it clears.
  assign load_use = load_E && we_E && (rd_E != '0) &&
                    ((rs1_used_D && (rs1_D == rd_E)) ||
                     (rs2_used_D && (rs2_D == rd_E)));
  assign sb_raw   = (rs1_used_D && (rs1_D != '0) && sb_pending[rs1_D]) ||
                    (rs2_used_D && (rs2_D != '0) && sb_pending[rs2_D]);
  assign sb_waw   = (rd_D != '0) && sb_pending[rd_D];
  assign hazard_D = load_use || sb_raw || sb_waw || (long_D && long_full);

  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    stall_E = 1'b0;
    flush_E = 1'b0;
    stall_M = 1'b0;
    flush_M = 1'b0;
    stall_W = 1'b0;
    flush_W = 1'b0;
    if (busy_M) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (je) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (hazard_D) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

endmodule

// File: tb/tb_hc_sb.sv
// tb_hc_sb: directed bench for hc_sb with a queue-based reference model of
// outstanding long ops and a per-cycle compare of every output.
module tb_hc_sb;
  import hc_sb_pkg::*;

  localparam int NREG     = 32;
  localparam int LONG_MAX = 4;
  localparam int REG_W    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             je, busy_M;
  logic [REG_W-1:0] rs1_D, rs2_D, rd_D;
  logic             rs1_used_D, rs2_used_D, long_D;
  logic [REG_W-1:0] rs1_E, rs2_E, rd_E;
  logic             we_E, load_E, long_E;
  logic [REG_W-1:0] rd_M, rd_W, long_rd;
  logic             we_M, we_W, long_done;
  logic             stall_F, stall_D, flush_D, stall_E, flush_E;
  logic             stall_M, flush_M, stall_W, flush_W;
  fwd_sel_t         fwd_a_E, fwd_b_E;
  logic [NREG-1:0]  sb_pending;
  logic             long_full, sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hc_sb #(.NREG(NREG), .LONG_MAX(LONG_MAX)) dut (
    .clk(clk), .reset(reset), .je(je), .busy_M(busy_M),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .rd_D(rd_D), .long_D(long_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .we_E(we_E), .load_E(load_E), .long_E(long_E),
    .rd_M(rd_M), .we_M(we_M), .rd_W(rd_W), .we_W(we_W),
    .long_done(long_done), .long_rd(long_rd),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .stall_E(stall_E), .flush_E(flush_E), .stall_M(stall_M), .flush_M(flush_M),
    .stall_W(stall_W), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .sb_pending(sb_pending), .long_full(long_full), .sb_err(sb_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  outstanding[$];   // destinations of long ops still in flight
  bit  m_err = 1'b0;
  bit  armed = 1'b0;
  bit  m_issue;
  int  m_idx;

  function automatic bit is_out(input int r);
    foreach (outstanding[i]) if (outstanding[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_fwd(input int rs);
    if (we_M && int'(rd_M) == rs && rd_M != 0) return 1;
    if (we_W && int'(rd_W) == rs && rd_W != 0) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      outstanding.delete();
      m_err = 1'b0;
      armed = 1'b1;
    end else begin
      m_issue = long_E && we_E && rd_E != 0 && !busy_M;
      if (long_done) begin
        m_idx = -1;
        foreach (outstanding[i]) if (outstanding[i] == int'(long_rd)) m_idx = i;
        if (m_idx < 0) m_err = 1'b1;
        else outstanding.delete(m_idx);
      end
      if (m_issue) outstanding.push_back(int'(rd_E));
    end
  end

  logic [8:0]      exp_ctrl;
  logic [NREG-1:0] exp_pend;
  bit              exp_hz;

  always @(negedge clk) begin
    if (armed) begin
      exp_pend = '0;
      foreach (outstanding[i]) exp_pend[outstanding[i]] = 1'b1;
      exp_hz = (load_E && we_E && rd_E != 0 &&
                ((rs1_used_D && rs1_D == rd_E) || (rs2_used_D && rs2_D == rd_E))) ||
               (rs1_used_D && rs1_D != 0 && is_out(int'(rs1_D))) ||
               (rs2_used_D && rs2_D != 0 && is_out(int'(rs2_D))) ||
               (rd_D != 0 && is_out(int'(rd_D))) ||
               (long_D && outstanding.size() == LONG_MAX);
      // order: stall_F stall_D flush_D stall_E flush_E stall_M flush_M stall_W flush_W
      if (busy_M)      exp_ctrl = 9'b110101001;
      else if (je)     exp_ctrl = 9'b001010000;
      else if (exp_hz) exp_ctrl = 9'b110010000;
      else             exp_ctrl = 9'b000000000;
      check("ctrl", {stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_M, stall_W, flush_W}, exp_ctrl);
      check("fwd_a", fwd_a_E, m_fwd(int'(rs1_E)));
      check("fwd_b", fwd_b_E, m_fwd(int'(rs2_E)));
      check("pending", sb_pending, exp_pend);
      check("full", long_full, outstanding.size() == LONG_MAX);
      check("err", sb_err, m_err);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    je = 0; busy_M = 0; rs1_D = 0; rs2_D = 0; rs1_used_D = 0; rs2_used_D = 0;
    rd_D = 0; long_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; we_E = 0; load_E = 0;
    long_E = 0; rd_M = 0; we_M = 0; rd_W = 0; we_W = 0; long_done = 0; long_rd = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic pin();
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    pin();
    check("rst_pending", sb_pending, 0);
    check("rst_full", long_full, 0);
    check("rst_err", sb_err, 0);
    check("rst_stall_F", stall_F, 0);
    check("rst_fwd_a", fwd_a_E, FWD_NONE);

    // Load-use
    nxt(); load_E = 1; we_E = 1; rd_E = 5; rs1_D = 5; rs1_used_D = 1; pin();
    check("lu_stall", {stall_F, stall_D, flush_E}, 3'b111);
    nxt(); we_M = 1; rd_M = 5; rs1_D = 5; rs1_used_D = 1; pin();
    check("lu_release", {stall_F, stall_D, flush_E}, 3'b000);
    nxt(); we_W = 1; rd_W = 5; rs1_E = 5; pin();
    check("lu_fwd_w", fwd_a_E, FWD_W);
    nxt(); load_E = 1; we_E = 1; rd_E = 6; rs2_D = 6; rs2_used_D = 0; pin();
    check("lu_unused_src", stall_D, 0);
    nxt(); load_E = 1; we_E = 1; rd_E = 0; rs1_D = 0; rs1_used_D = 1; pin();
    check("lu_x0", stall_D, 0);

    // Back-to-back ALU forwarding
    nxt(); we_M = 1; rd_M = 3; we_W = 1; rd_W = 3; rs1_E = 3; rs2_E = 3; pin();
    check("fwd_m_prio_a", fwd_a_E, FWD_M);
    check("fwd_m_prio_b", fwd_b_E, FWD_M);
    nxt(); we_M = 1; rd_M = 0; we_W = 1; rd_W = 0; pin();
    check("fwd_x0_a", fwd_a_E, FWD_NONE);
    nxt(); we_M = 1; rd_M = 4; we_W = 1; rd_W = 3; rs1_E = 3; rs2_E = 4; pin();
    check("fwd_mix_a", fwd_a_E, FWD_W);
    check("fwd_mix_b", fwd_b_E, FWD_M);
    nxt(); we_M = 0; rd_M = 3; rs1_E = 3; pin();
    check("fwd_no_we", fwd_a_E, FWD_NONE);

    // Long op x7, retiring 10 cycles after issue
    nxt(); long_E = 1; we_E = 1; rd_E = 7; pin();
    check("long_pre", sb_pending[7], 0);
    for (int i = 0; i < 9; i++) begin
      nxt(); rs1_D = 7; rs1_used_D = 1; pin();
      check("long_wait_pend", sb_pending[7], 1);
      check("long_wait_stall", stall_D, 1);
    end
    nxt(); long_done = 1; long_rd = 7; rs1_D = 7; rs1_used_D = 1; pin();
    check("long_done_stall", stall_D, 1);
    nxt(); rs1_D = 7; rs1_used_D = 1; pin();
    check("long_after_stall", stall_D, 0);
    check("long_after_pend", sb_pending[7], 0);

    // Full
    for (int r = 1; r <= 4; r++) begin
      nxt(); long_E = 1; we_E = 1; rd_E = REG_W'(r);
    end
    nxt(); long_D = 1; rd_D = 5; long_done = 1; long_rd = 2; pin();
    check("full_flag", long_full, 1);
    check("full_stall", stall_D, 1);
    check("full_pend", sb_pending, 32'h1E);
    nxt(); long_D = 1; rd_D = 5; pin();
    check("full_release", long_full, 0);
    check("full_go", stall_D, 0);
    check("full_pend2", sb_pending, 32'h1A);
    nxt(); long_E = 1; we_E = 1; rd_E = 5;
    nxt(); pin();
    check("full_pend3", sb_pending, 32'h3A);
    nxt(); long_done = 1; long_rd = 1;
    nxt(); long_done = 1; long_rd = 3;
    nxt(); long_done = 1; long_rd = 4;
    nxt(); long_done = 1; long_rd = 5;
    nxt(); pin();
    check("drain_pend", sb_pending, 0);
    check("drain_err", sb_err, 0);

    // busy_M dominating je, RAW, and a blocked issue; done still retires
    nxt(); long_E = 1; we_E = 1; rd_E = 9;
    nxt(); busy_M = 1; je = 1; rs1_D = 9; rs1_used_D = 1; long_done = 1; long_rd = 9;
    long_E = 1; we_E = 1; rd_E = 12; we_M = 1; rd_M = 8; rs2_E = 8; pin();
    check("busy_ctrl", {stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_M, stall_W, flush_W}, 9'b110101001);
    check("busy_fwd", fwd_b_E, FWD_M);
    nxt(); je = 1; rs1_D = 9; rs1_used_D = 1; pin();
    check("je_ctrl", {stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_M, stall_W, flush_W}, 9'b001010000);
    check("busy_pend", sb_pending, 0);
    nxt(); rs1_D = 9; rs1_used_D = 1; pin();
    check("quiet_ctrl", stall_F, 0);

    // Scoreboard errors and reset
    nxt(); long_E = 1; we_E = 1; rd_E = 10;
    nxt(); long_done = 1; long_rd = 11; pin();
    check("err_before", sb_err, 0);
    nxt(); rd_D = 10; pin();
    check("err_bitclear", sb_err, 1);
    check("err_keep_pend", sb_pending, 32'h400);
    check("waw_stall", stall_D, 1);
    nxt(); reset = 1;
    nxt(); reset = 0; pin();
    check("rst2_err", sb_err, 0);
    check("rst2_pend", sb_pending, 0);
    nxt(); long_done = 1; long_rd = 6;
    nxt(); pin();
    check("err_cnt0", sb_err, 1);
    check("err_cnt0_pend", sb_pending, 0);
    nxt(); pin();
    check("err_sticky", sb_err, 1);
    nxt(); reset = 1;
    nxt(); reset = 0; pin();
    check("rst3_err", sb_err, 0);
    check("rst3_pend", sb_pending, 0);

    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc_sb.md
Name: hc_sb

Overview:
- Second-generation hazard controller for the 5-stage core: F, D, E, M, W.
- Keeps the existing global-stall, jump-flush and RAW-stall priorities.
- Adds E-stage operand forwarding from M/W, single-cycle load-use stall detection, and a register scoreboard for long-latency ops (MDU) that retire out of band.
- Sits beside the pipeline registers and drives their stall/flush inputs, plus the E-stage operand mux selects.

Parameters:
NREG, 32, number of architectural registers (x0 hardwired zero)
LONG_MAX, 4, maximum outstanding long-latency ops
REG_W, $clog2(NREG), register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
je  in  1  jump/branch taken, resolved in E
busy_M  in  1  LSU busy, whole pipe must hold
rs1_D, rs2_D  in  REG_W  source registers of the instruction in D
rs1_used_D, rs2_used_D  in  1  source actually read
rd_D  in  REG_W  destination of the instruction in D
long_D  in  1  instruction in D is a long-latency op
rs1_E, rs2_E  in  REG_W  sources of the instruction in E
rd_E  in  REG_W  destination of the instruction in E
we_E, load_E, long_E  in  1  E writes rd / E is a load / E is a long op
rd_M  in  REG_W  destination in M
we_M  in  1  M writes rd
rd_W  in  REG_W  destination in W
we_W  in  1  W writes rd
long_done  in  1  long unit writing its result this cycle
long_rd  in  REG_W  destination of that result
stall_F  out  1  hold fetch
stall_D, flush_D  out  1  FD register hold / bubble
stall_E, flush_E  out  1  DE register hold / bubble
stall_M, flush_M  out  1  EM register hold / bubble
stall_W, flush_W  out  1  MW register hold / bubble
fwd_a_E, fwd_b_E  out  2  fwd_sel_t operand select for E
sb_pending  out  NREG  scoreboard bits
long_full  out  1  outstanding count == LONG_MAX
sb_err  out  1  sticky: long_done with count 0 or with its bit clear

Behaviour:
Combinational control, evaluated in priority order:
1. busy_M: assert stall_F/D/E/M and flush_W. All else 0; je and hazards are ignored this cycle.
2. Else je: assert flush_D and flush_E. Hazards are not checked.
3. Else hazard_D: assert stall_F, stall_D and flush_E. hazard_D is the OR of:
   - Load-use: load_E & we_E & rd_E!=0, and rd_E matches a used rs*_D.
   - Scoreboard RAW: sb_pending[rs*_D] for any used source, with rs*_D != 0.
   - Scoreboard WAW: sb_pending[rd_D] & rd_D != 0.
   - Long full: long_D & long_full.
- stall_M, flush_M and stall_W are 0 outside busy_M.

Forwarding, per E operand (fwd_a_E from rs1_E, fwd_b_E from rs2_E):
- FWD_M if we_M & rd_M==rs & rd_M!=0.
- Else FWD_W if we_W & rd_W==rs & rd_W!=0.
- Else FWD_NONE. M wins over W.
- Selects are pure combinational, valid even during a stall.
- The load-use stall guarantees a load's value is only ever taken from W.
- There is no bypass of long_done. A D reader of the retiring register stalls that cycle (bit still set) and proceeds the next.

Scoreboard (sequential):
- issue = long_E & we_E & rd_E!=0 & !busy_M, i.e. the op leaves E.
- On issue: set sb_pending[rd_E] and increment count.
- On long_done: clear sb_pending[long_rd] and decrement count.
- Issue and done in the same cycle: count unchanged. Set wins if the registers coincide (unreachable, since WAW is stalled).
- Count never exceeds LONG_MAX; long_D is stalled at full.
- long_done with count==0 or its bit clear: no decrement, no change to the bit, sb_err←1.
- long_done is processed during busy_M.
- Bit 0 is never set.

Reset: sb_pending=0, count=0, sb_err=0, long_full=0. Every combinational output is 0 / FWD_NONE when its inputs are quiescent. Reset mid-operation discards outstanding entries, and the long unit is reset in the same cycle.

Decomposition:
- Package pipeline: typedef enum logic [1:0] fwd_sel_t {FWD_NONE=0, FWD_M=1, FWD_W=2}; LONG_MAX default constant.
- Sub-module hc_scoreboard holds pending bits, counter, full and err. It takes issue/issue_rd and done/done_rd, and exposes pending.
- Priority logic and forwarding stay in hc_sb.

Test Plan:
- Load-use: load x5 in E, D reads x5 → one cycle of stall_F=stall_D=flush_E=1; next cycle fwd_a_E=FWD_W.
- Back-to-back ALU: add x3 in M, D-then-E reads x3 with x3 also in W → fwd_a_E=FWD_M (M priority); x0 destinations → FWD_NONE.
- Long op: issue div x7; 10 cycles later long_done x7. A D reader of x7 stalls through the done cycle and issues the cycle after. sb_pending[7] goes 1 then 0.
- Full: 4 long ops to x1..x4 outstanding, 5th long_D → stall with long_full=1. long_done x2 that cycle → count 3, 5th issues next cycle.
- busy_M with je and a pending RAW simultaneously → only stall F/D/E/M and flush_W. Release busy_M → flush_D=flush_E=1. A long_done during busy clears its bit.
- long_done with count 0 → sb_err=1 and sticky; reset → sb_err=0, sb_pending=0.
